// File: rtl/radix_4_otfc_decoder_if.sv
// Handshake bundle between the divider iteration datapath, the OTFC decoder and the result stage.
interface radix_4_otfc_decoder_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
);
  logic             start_valid_i;
  logic             start_ready_o;
  logic [CNT_W-1:0] iter_num_i;
  logic             quot_dig_valid_i;
  logic             quot_dig_ready_o;
  logic [4:0]       quot_dig_i;
  logic             rem_sign_valid_i;
  logic             rem_sign_i;
  logic             finish_valid_o;
  logic             finish_ready_i;
  logic [WIDTH-1:0] quot_o;
  logic             dig_err_o;

  modport master (
    output start_valid_i, iter_num_i, quot_dig_valid_i, quot_dig_i,
           rem_sign_valid_i, rem_sign_i, finish_ready_i,
    input  start_ready_o, quot_dig_ready_o, finish_valid_o, quot_o, dig_err_o
  );

  modport slave (
    input  start_valid_i, iter_num_i, quot_dig_valid_i, quot_dig_i,
           rem_sign_valid_i, rem_sign_i, finish_ready_i,
    output start_ready_o, quot_dig_ready_o, finish_valid_o, quot_o, dig_err_o
  );
endinterface

// File: rtl/radix_4_otfc_decoder.sv
// Radix-4 on-the-fly quotient conversion (Q / QM) with final negative-remainder correction.
// Latency: one cycle per accepted digit, one cycle in FIX once the remainder sign arrives.
// Backpressure: stalls indefinitely on missing digits/sign; holds result until finish_ready_i.
module radix_4_otfc_decoder #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  radix_4_otfc_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_DIG = CNT_W'(WIDTH/2);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q, qm, q_nxt, qm_nxt, quot;
  logic             dig_err;
  logic             start_rdy, dig_rdy, fin_vld;
  logic             start_hs, dig_hs, fix_hs, fin_hs;
  logic [WIDTH-3:0] q_lo, qm_lo;

  assign start_hs = start_rdy & bus.start_valid_i;
  assign dig_hs   = dig_rdy & bus.quot_dig_valid_i;
  assign fix_hs   = (state == FIX) & bus.rem_sign_valid_i;
  assign fin_hs   = fin_vld & bus.finish_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_hs) state_nxt = ITER;
      ITER:    if (dig_hs && cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     if (fix_hs) state_nxt = DONE;
      DONE:    if (fin_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_rdy = 1'b0;
    dig_rdy   = 1'b0;
    fin_vld   = 1'b0;
    case (state)
      IDLE:    start_rdy = 1'b1;
      ITER:    dig_rdy   = 1'b1;
      DONE:    fin_vld   = 1'b1;
      default: ;
    endcase
  end

  assign q_lo  = q[WIDTH-3:0];
  assign qm_lo = qm[WIDTH-3:0];

  // Malformed (non-one-hot) digits fall into the default arm and act as a zero digit.
  always_comb begin
    q_nxt  = {q_lo, 2'b00};
    qm_nxt = {qm_lo, 2'b11};
    case (bus.quot_dig_i)
      5'b10000: begin q_nxt = {q_lo, 2'b10};  qm_nxt = {q_lo, 2'b01};  end
      5'b01000: begin q_nxt = {q_lo, 2'b01};  qm_nxt = {q_lo, 2'b00};  end
      5'b00010: begin q_nxt = {qm_lo, 2'b11}; qm_nxt = {qm_lo, 2'b10}; end
      5'b00001: begin q_nxt = {qm_lo, 2'b10}; qm_nxt = {qm_lo, 2'b01}; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      qm      <= '1;
      cnt     <= '0;
      quot    <= '0;
      dig_err <= 1'b0;
    end else begin
      if (start_hs) begin
        q       <= '0;
        qm      <= '1;
        dig_err <= 1'b0;
        cnt     <= (bus.iter_num_i == '0 || bus.iter_num_i > MAX_DIG) ? MAX_DIG : bus.iter_num_i;
      end else if (dig_hs) begin
        q   <= q_nxt;
        qm  <= qm_nxt;
        cnt <= cnt - CNT_W'(1);
        if (!$onehot(bus.quot_dig_i)) dig_err <= 1'b1;
      end
      if (fix_hs) quot <= bus.rem_sign_i ? qm : q;
    end
  end

  assign bus.start_ready_o    = start_rdy;
  assign bus.quot_dig_ready_o = dig_rdy;
  assign bus.finish_valid_o   = fin_vld;
  assign bus.quot_o           = quot;
  assign bus.dig_err_o        = dig_err;

endmodule

// File: tb/tb_radix_4_otfc_decoder.sv
// Randomized + directed bench for radix_4_otfc_decoder (WIDTH=8) against an arithmetic quotient model.
module tb_radix_4_otfc_decoder;

  localparam int WIDTH = 8;
  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = $clog2(WIDTH/2) + 1;

  logic clk = 1'b0;
  logic rst;

  radix_4_otfc_decoder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  radix_4_otfc_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs, maintained by the driver from the protocol it is driving.
  logic             exp_sr, exp_dr, exp_fv, exp_err;
  logic [WIDTH-1:0] exp_quot;

  logic [4:0] dig_code [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    chk("start_ready", 32'(bus.start_ready_o), 32'(exp_sr));
    chk("dig_ready", 32'(bus.quot_dig_ready_o), 32'(exp_dr));
    chk("finish_valid", 32'(bus.finish_valid_o), 32'(exp_fv));
    chk("quot", 32'(bus.quot_o), 32'(exp_quot));
    chk("dig_err", 32'(bus.dig_err_o), 32'(exp_err));
  end

  function automatic logic [4:0] enc(input int d);
    logic [4:0] one;
    one = 5'b00001;
    return one << (d + 2);
  endfunction

  function automatic int dec(input logic [4:0] c);
    if (!$onehot(c)) return 0;
    for (int i = 0; i < 5; i++) if (c[i]) return i - 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; the model value is the plain radix-4 digit sum minus the sign correction.
  task automatic run_op(input int iter, input int gmin, input int gmax, input logic sign,
                        input int fix_wait, input int fin_wait);
    int n;
    int v;
    int g;
    n = (iter == 0 || iter > HALF) ? HALF : iter;
    bus.start_valid_i = 1'b1;
    bus.iter_num_i    = CNT_W'(iter);
    tick();
    bus.start_valid_i = 1'b0;
    bus.iter_num_i    = CNT_W'($urandom);
    exp_sr = 1'b0; exp_dr = 1'b1; exp_err = 1'b0;
    v = 0;
    for (int i = 0; i < n; i++) begin
      g = int'($urandom_range(gmax, gmin));
      for (int k = 0; k < g; k++) begin
        bus.quot_dig_valid_i = 1'b0;
        bus.quot_dig_i       = 5'($urandom);
        bus.rem_sign_valid_i = 1'($urandom);
        bus.rem_sign_i       = 1'($urandom);
        tick();
      end
      bus.quot_dig_valid_i = 1'b1;
      bus.quot_dig_i       = dig_code[i];
      bus.rem_sign_valid_i = 1'($urandom);
      tick();
      bus.quot_dig_valid_i = 1'b0;
      v = v * 4 + dec(dig_code[i]);
      if (!$onehot(dig_code[i])) exp_err = 1'b1;
    end
    bus.rem_sign_valid_i = 1'b0;
    exp_dr = 1'b0;
    for (int k = 0; k < fix_wait; k++) tick();
    bus.rem_sign_valid_i = 1'b1;
    bus.rem_sign_i       = sign;
    tick();
    bus.rem_sign_valid_i = 1'b0;
    exp_fv   = 1'b1;
    exp_quot = WIDTH'(v - int'(sign));
    for (int k = 0; k < fin_wait; k++) begin
      bus.finish_ready_i = 1'b0;
      bus.start_valid_i  = 1'($urandom);
      tick();
    end
    bus.finish_ready_i = 1'b1;
    tick();
    bus.finish_ready_i = 1'b0;
    bus.start_valid_i  = 1'b0;
    exp_fv = 1'b0;
    exp_sr = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_valid_i    = 1'b0;
    bus.iter_num_i       = '0;
    bus.quot_dig_valid_i = 1'b0;
    bus.quot_dig_i       = '0;
    bus.rem_sign_valid_i = 1'b0;
    bus.rem_sign_i       = 1'b0;
    bus.finish_ready_i   = 1'b0;
    exp_sr = 1'b1; exp_dr = 1'b0; exp_fv = 1'b0; exp_err = 1'b0; exp_quot = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // +2,+1 with a 5-cycle finish stall
    dig_code[0] = enc(2); dig_code[1] = enc(1);
    run_op(2, 0, 0, 1'b0, 0, 5);
    chk("lit_09", 32'(bus.quot_o), 32'h09);
    chk("lit_09_err", 32'(bus.dig_err_o), 32'h0);

    dig_code[0] = enc(-1); dig_code[1] = enc(2);
    run_op(2, 0, 0, 1'b0, 0, 0);
    chk("lit_fe", 32'(bus.quot_o), 32'hFE);
    run_op(2, 0, 0, 1'b1, 1, 0);
    chk("lit_fd", 32'(bus.quot_o), 32'hFD);

    dig_code[0] = enc(1); dig_code[1] = enc(0); dig_code[2] = enc(-2); dig_code[3] = enc(-1);
    run_op(4, 2, 2, 1'b0, 0, 0);
    chk("lit_37", 32'(bus.quot_o), 32'h37);

    dig_code[0] = 5'b00011; dig_code[1] = enc(1);
    run_op(2, 0, 0, 1'b0, 0, 1);
    chk("lit_01", 32'(bus.quot_o), 32'h01);
    chk("lit_err_set", 32'(bus.dig_err_o), 32'h1);

    // reset pulse mid-ITER after one digit
    bus.start_valid_i = 1'b1;
    bus.iter_num_i    = CNT_W'(2);
    tick();
    bus.start_valid_i = 1'b0;
    exp_sr = 1'b0; exp_dr = 1'b1; exp_err = 1'b0;
    bus.quot_dig_valid_i = 1'b1;
    bus.quot_dig_i       = enc(2);
    tick();
    bus.quot_dig_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    exp_sr = 1'b1; exp_dr = 1'b0; exp_fv = 1'b0; exp_err = 1'b0; exp_quot = '0;
    chk("rst_quot", 32'(bus.quot_o), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    dig_code[0] = enc(2); dig_code[1] = enc(1);
    run_op(2, 0, 0, 1'b0, 0, 0);
    chk("lit_09_after_rst", 32'(bus.quot_o), 32'h09);

    for (int t = 0; t < 250; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7, 0) == 0) begin
          logic [4:0] c;
          c = 5'($urandom);
          while ($onehot(c)) c = 5'($urandom);
          dig_code[i] = c;
        end else begin
          dig_code[i] = enc(int'($urandom_range(4, 0)) - 2);
        end
      end
      run_op(int'($urandom_range(7, 0)), 0, 2, 1'($urandom),
             int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
      if ($urandom_range(3, 0) == 0) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
